// File: rtl/free_list_pkg.sv
// Shared rename-path constants and the physical tag type used by the free list, ROB and map tables.
// No logic; compile-time definitions only.
// Imported by every rename-path block that handles physical tags or free-list pointers.
package free_list_pkg;

  localparam int FL_DEPTH  = 32;
  localparam int PRF_TAG_W = 6;
  localparam int ARCH_REGS = 32;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH) + 1;

  typedef logic [PRF_TAG_W-1:0] prf_tag_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: dispatch pops, retire pushes, mispredict restores head.
// Latency: head tag is combinational (zero latency); pops/pushes take effect at the next rising edge.
// Backpressure: alloc is granted only while non-empty and not recovering; a free while full is dropped and flagged.
module free_list #(
  parameter int FL_DEPTH  = free_list_pkg::FL_DEPTH,
  parameter int TAG_W     = free_list_pkg::PRF_TAG_W,
  parameter int ARCH_REGS = free_list_pkg::ARCH_REGS,
  parameter int PTR_W     = free_list_pkg::FL_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fl_alloc_req_i,
  output logic [TAG_W-1:0] fl_tag_o,
  output logic             fl_tag_vld_o,
  input  logic             fl_free_vld_i,
  input  logic [TAG_W-1:0] fl_free_tag_i,
  input  logic             fl_recover_i,
  input  logic [PTR_W-1:0] fl_recover_head_i,
  output logic [PTR_W-1:0] fl_head_o,
  output logic [PTR_W-1:0] fl_cnt_o,
  output logic             fl_empty_o,
  output logic             fl_full_o,
  output logic             fl_ovf_err_o
);
  import free_list_pkg::*;

  // Low bits index the storage; the MSB is a wrap bit that separates full from empty.
  localparam int IDX_W = PTR_W - 1;

  logic [TAG_W-1:0] entry_q [FL_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic             ovf_q;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             empty;
  logic             full;
  logic             alloc_gnt;
  logic             free_ok;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Pointers equal means nothing between them; same index with opposite wrap bits means a full lap.
  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  // Recovery overrides dispatch: the head is being rewound, so nothing is handed out that cycle.
  assign alloc_gnt = fl_alloc_req_i && !empty && !fl_recover_i;
  assign free_ok   = fl_free_vld_i && !full;

  assign fl_tag_o     = empty ? '0 : entry_q[head_idx];
  assign fl_tag_vld_o = !empty;
  assign fl_head_o    = head_q;
  assign fl_cnt_o     = tail_q - head_q;
  assign fl_empty_o   = empty;
  assign fl_full_o    = full;
  assign fl_ovf_err_o = ovf_q;

  // Storage: reset loads the tags not mapped architecturally; retire writes the returned tag at tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= TAG_W'(ARCH_REGS + i);
      end
    end else if (free_ok) begin
      entry_q[tail_idx] <= fl_free_tag_i;
    end
  end

  // Head: advances on a granted alloc, or jumps to the checkpoint on recovery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
    end else if (fl_recover_i) begin
      head_q <= fl_recover_head_i;
    end else if (alloc_gnt) begin
      head_q <= head_q + 1'b1;
    end
  end

  // Tail: advances on an accepted free; a recovery cycle still retires because the retiring op is older.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q <= PTR_W'(FL_DEPTH);
    end else if (free_ok) begin
      tail_q <= tail_q + 1'b1;
    end
  end

  // Overflow flag: sticky record of a free that found no room, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (fl_free_vld_i && full) begin
      ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed rename scenarios followed by randomized traffic.
// The reference is a queue of free tags plus a history of handed-out tags used to undo allocations.
// Outputs are sampled on the falling edge; inputs change only on the falling edge or between edges for reset.
module tb_free_list;

  logic       clk;
  logic       rst;
  logic       fl_alloc_req_i;
  logic [5:0] fl_tag_o;
  logic       fl_tag_vld_o;
  logic       fl_free_vld_i;
  logic [5:0] fl_free_tag_i;
  logic       fl_recover_i;
  logic [5:0] fl_recover_head_i;
  logic [5:0] fl_head_o;
  logic [5:0] fl_cnt_o;
  logic       fl_empty_o;
  logic       fl_full_o;
  logic       fl_ovf_err_o;

  free_list dut (
    .clk               (clk),
    .rst               (rst),
    .fl_alloc_req_i    (fl_alloc_req_i),
    .fl_tag_o          (fl_tag_o),
    .fl_tag_vld_o      (fl_tag_vld_o),
    .fl_free_vld_i     (fl_free_vld_i),
    .fl_free_tag_i     (fl_free_tag_i),
    .fl_recover_i      (fl_recover_i),
    .fl_recover_head_i (fl_recover_head_i),
    .fl_head_o         (fl_head_o),
    .fl_cnt_o          (fl_cnt_o),
    .fl_empty_o        (fl_empty_o),
    .fl_full_o         (fl_full_o),
    .fl_ovf_err_o      (fl_ovf_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: free tags in hand-out order, tags handed out (oldest first), head count, overflow.
  logic [5:0] fl_q[$];
  logic [5:0] hist[$];
  int         m_head;
  bit         m_ovf;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fl_q.delete();
    hist.delete();
    for (int i = 0; i < 32; i++) fl_q.push_back(6'(32 + i));
    m_head = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    int sz;
    sz = fl_q.size();
    chk({where, ".cnt"},   int'(fl_cnt_o),     sz);
    chk({where, ".tag"},   int'(fl_tag_o),     (sz > 0) ? int'(fl_q[0]) : 0);
    chk({where, ".vld"},   int'(fl_tag_vld_o), (sz > 0) ? 1 : 0);
    chk({where, ".empty"}, int'(fl_empty_o),   (sz == 0) ? 1 : 0);
    chk({where, ".full"},  int'(fl_full_o),    (sz == 32) ? 1 : 0);
    chk({where, ".head"},  int'(fl_head_o),    m_head);
    chk({where, ".ovf"},   int'(fl_ovf_err_o), int'(m_ovf));
  endtask

  task automatic idle_inputs();
    fl_alloc_req_i    = 1'b0;
    fl_free_vld_i     = 1'b0;
    fl_free_tag_i     = '0;
    fl_recover_i      = 1'b0;
    fl_recover_head_i = '0;
  endtask

  // Called on a falling edge: pulse reset asynchronously, check, release before the next rising edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    #1;
    rst = 1'b1;
  endtask

  // One clock: check current outputs, drive a request, let the edge pass, advance the reference.
  task automatic cyc(input bit a, input bit f, input logic [5:0] ft, input bit r, input logic [5:0] rh);
    int sz;
    int k;
    bit gnt;
    bit fok;
    check_outputs("cyc");
    fl_alloc_req_i    = a;
    fl_free_vld_i     = f;
    fl_free_tag_i     = ft;
    fl_recover_i      = r;
    fl_recover_head_i = rh;
    sz  = fl_q.size();
    gnt = a && (sz > 0) && !r;
    fok = f && (sz < 32);
    @(posedge clk);
    if (f && sz == 32) m_ovf = 1'b1;
    if (gnt) begin
      hist.push_back(fl_q.pop_front());
      m_head = (m_head + 1) % 64;
    end
    if (r) begin
      // Rewinding the head re-offers the most recent allocations, newest at the back of the re-offered run.
      k = (m_head - int'(rh) + 64) % 64;
      repeat (k) fl_q.push_front(hist.pop_back());
      m_head = int'(rh);
    end
    if (fok) fl_q.push_back(ft);
    while (hist.size() > 64) void'(hist.pop_front());
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Drain the whole list back-to-back: tags come out 32..63 in order.
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", int'(fl_tag_o), 32 + i);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    end
    chk("drained_empty", int'(fl_empty_o), 1);
    chk("drained_vld", int'(fl_tag_vld_o), 0);
    chk("drained_cnt", int'(fl_cnt_o), 0);

    // Empty list: a same-cycle free is not bypassed to the alloc.
    cyc(1'b1, 1'b1, 6'd40, 1'b0, 6'd0);
    chk("nobypass_tag", int'(fl_tag_o), 40);
    chk("nobypass_cnt", int'(fl_cnt_o), 1);

    // Build up to ten entries, then steady alloc+free across the pointer wrap.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 6'(10 + i), 1'b0, 6'd0);
    for (int i = 0; i < 40; i++) begin
      chk("steady_cnt", int'(fl_cnt_o), 10);
      cyc(1'b1, 1'b1, 6'(5 + (i % 20)), 1'b0, 6'd0);
    end
    chk("steady_cnt_end", int'(fl_cnt_o), 10);
    chk("steady_head", int'(fl_head_o), (32 + 40) % 64);

    // Checkpoint at head 3, allocate 4 more, recover with a competing alloc.
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("ckpt_head", int'(fl_head_o), 3);
    repeat (4) cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("pre_rec_cnt", int'(fl_cnt_o), 25);
    cyc(1'b1, 1'b0, 6'd0, 1'b1, 6'd3);
    chk("rec_tag", int'(fl_tag_o), 35);
    chk("rec_cnt", int'(fl_cnt_o), 29);

    // Free into a full list: dropped and flagged, flag stays set.
    do_reset();
    cyc(1'b0, 1'b1, 6'd7, 1'b0, 6'd0);
    chk("ovf_cnt", int'(fl_cnt_o), 32);
    chk("ovf_flag", int'(fl_ovf_err_o), 1);
    repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("ovf_sticky", int'(fl_ovf_err_o), 1);

    // Asynchronous reset between edges in the middle of an alloc burst.
    fl_alloc_req_i = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_cnt", int'(fl_cnt_o), 32);
    chk("areset_tag", int'(fl_tag_o), 32);
    chk("areset_ovf", int'(fl_ovf_err_o), 0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    check_outputs("post_areset");

    // Randomized traffic, keeping recovery checkpoints within legal reach.
    for (int n = 0; n < 3000; n++) begin
      bit a, f, r;
      logic [5:0] ft, rh;
      int sz, kmax, k;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        sz   = fl_q.size();
        a    = ($urandom_range(0, 99) < 55);
        f    = ($urandom_range(0, 99) < 50);
        ft   = 6'($urandom_range(0, 63));
        r    = ($urandom_range(0, 99) < 5);
        rh   = 6'(m_head);
        if (r) begin
          kmax = 32 - sz;
          if (hist.size() < kmax) kmax = hist.size();
          k  = $urandom_range(0, kmax);
          rh = 6'((m_head - k + 64) % 64);
          if (sz + k >= 32) f = 1'b0;
        end
        cyc(a, f, ft, r, rh);
      end
    end
    check_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
